// File: rtl/spi_frame_receiver.sv
// SPI mode-0 command receiver: synchronizes SCK/CS_N/SDI into clk,
// shifts MSB-first and emits a strobe per frame of exactly DATA_WIDTH bits.
module spi_frame_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_in,
  input  logic                  cs_n_in,
  input  logic                  sdi_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_rdy,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sr;
  logic [SYNC_STAGES-1:0]  cs_sr;
  logic [SYNC_STAGES-1:0]  sdi_sr;
  logic [SYNC_STAGES-1:0]  vld_sr;
  logic                    sck_hist;
  logic                    cs_hist;
  logic                    armed;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [CW-1:0]           cnt;

  logic sck_sync, cs_sync, sdi_sync;
  logic sck_rise, cs_rise, cs_fall;

  assign sck_sync = sck_sr[SYNC_STAGES-1];
  assign cs_sync  = cs_sr[SYNC_STAGES-1];
  assign sdi_sync = sdi_sr[SYNC_STAGES-1];

  assign sck_rise = sck_sync & ~sck_hist;
  assign cs_rise  = cs_sync & ~cs_hist;
  // A CS_N fall only counts once the host has been seen deselected,
  // so a reset in the middle of a frame cannot reopen that frame.
  assign cs_fall  = armed & ~cs_sync & cs_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sr   <= '0;
      cs_sr    <= '1;
      sdi_sr   <= '0;
      vld_sr   <= '0;
      sck_hist <= 1'b0;
      cs_hist  <= 1'b1;
      armed    <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck_in};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs_n_in};
      sdi_sr   <= {sdi_sr[SYNC_STAGES-2:0], sdi_in};
      vld_sr   <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
      sck_hist <= sck_sync;
      cs_hist  <= cs_sync;
      if (vld_sr[SYNC_STAGES-1] && cs_sync) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt       <= '0;
      data_out  <= '0;
      data_rdy  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      data_rdy  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            shift_q <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (cnt == CNT_FULL) begin
              data_out <= shift_q;
              data_rdy <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sck_rise) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], sdi_sync};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomized bench for spi_frame_receiver against a frame-level model:
// a frame is valid iff exactly DW bits were clocked while CS_N was low.
module tb_spi_frame_receiver;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck_in = 1'b0;
  logic cs_n_in = 1'b1;
  logic sdi_in = 1'b0;
  logic [DW-1:0] data_out;
  logic data_rdy;
  logic frame_err;
  logic busy;

  int checks = 0;
  int errors = 0;
  int rdy_seen = 0;
  int err_seen = 0;
  int exp_rdy = 0;
  int exp_err = 0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_frame_receiver #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sck_in   (sck_in),
    .cs_n_in  (cs_n_in),
    .sdi_in   (sdi_in),
    .data_out (data_out),
    .data_rdy (data_rdy),
    .frame_err(frame_err),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_rdy) begin
        rdy_seen++;
        got_q.push_back(data_out);
        chk("busy_low_at_rdy", 64'(busy), 64'd0);
      end
      if (frame_err) err_seen++;
      if (data_rdy || frame_err)
        chk("strobe_excl", 64'(data_rdy & frame_err), 64'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sck(input logic b);
    sdi_in = b;
    tick(3);
    sck_in = 1'b1;
    tick(3);
    sck_in = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n,
                            input bit tail_col, input bit lead_col,
                            input int rst_after, input int gap);
    bit aborted;
    aborted = 1'b0;
    if (lead_col) begin
      sdi_in = 1'($urandom);
      sck_in = 1'b1;
    end
    cs_n_in = 1'b0;
    tick(3);
    sck_in = 1'b0;
    tick(1);
    chk("busy_in_frame", 64'(busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      pulse_sck(bits[n-1-i]);
      if (i + 1 == rst_after) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        aborted = 1'b1;
      end
    end
    tick(3);
    if (tail_col) begin
      sdi_in = 1'($urandom);
      sck_in = 1'b1;
      cs_n_in = 1'b1;
      tick(3);
      sck_in = 1'b0;
    end else begin
      cs_n_in = 1'b1;
    end
    tick(gap);
    if (aborted) begin
      exp_data = '0;
    end else if (n == DW) begin
      exp_rdy++;
      exp_data = bits[DW-1:0];
      exp_q.push_back(exp_data);
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_all(input string tag);
    tick(8);
    chk({tag, "_rdy_cnt"}, 64'(rdy_seen), 64'(exp_rdy));
    chk({tag, "_err_cnt"}, 64'(err_seen), 64'(exp_err));
    chk({tag, "_data"}, 64'(data_out), 64'(exp_data));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_rdy_val"}, 64'(got_q.pop_front()),
          64'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] r;
    int n;
    bit tc, lc;

    rst = 1'b1;
    tick(3);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_rdy", 64'(data_rdy), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick(5);

    send_frame(64'h8A5C, 16, 0, 0, -1, 4);
    check_all("valid");
    send_frame(64'h1234, 15, 0, 0, -1, 4);
    check_all("short");
    r = {$urandom, $urandom};
    send_frame(r, 20, 0, 0, -1, 4);
    check_all("long");
    r = {$urandom, $urandom};
    send_frame(r, 48, 0, 0, -1, 4);
    check_all("no_wrap");

    cs_n_in = 1'b1;
    for (int i = 0; i < 40; i++) pulse_sck(1'($urandom));
    check_all("idle_noise");

    r = {$urandom, $urandom};
    send_frame(r, 16, 0, 0, 8, 4);
    check_all("rst_mid");
    send_frame(64'hF00F, 16, 0, 0, -1, 4);
    check_all("after_rst");

    send_frame(64'h0001, 16, 0, 0, -1, 2);
    send_frame(64'hFFFE, 16, 0, 0, -1, 4);
    check_all("b2b");

    send_frame(64'hC3A5, 16, 1, 0, -1, 4);
    check_all("tail_col");
    send_frame(64'h5AA5, 16, 0, 1, -1, 4);
    check_all("lead_col");

    for (int k = 0; k < 30; k++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0, 1: n = 16;
        2: n = 15;
        3: n = 17;
        default: n = int'($urandom_range(0, 20));
      endcase
      tc = ($urandom_range(0, 3) == 0);
      lc = ($urandom_range(0, 3) == 0);
      send_frame(r, n, tc, lc, -1, int'($urandom_range(2, 5)));
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
